// File: rtl/pid_pkg.sv
// Shared definitions for the PID math sequencer: FSM states, ALU select
// encodings and the per-state ALU control word.
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        INTG,
        ICOMP,
        PCOMP,
        ACC1,
        ACC2,
        DONE
    } state_t;

    // ALU src0 select encodings
    localparam logic [2:0] SRC0_A2D_RES    = 3'd0;
    localparam logic [2:0] SRC0_INTGRL_EXT = 3'd1;
    localparam logic [2:0] SRC0_ICOMP_EXT  = 3'd2;
    localparam logic [2:0] SRC0_PCOMP      = 3'd3;
    localparam logic [2:0] SRC0_PTERM      = 3'd4;

    // ALU src1 select encodings
    localparam logic [2:0] SRC1_ACCUM      = 3'd0;
    localparam logic [2:0] SRC1_ITERM      = 3'd1;
    localparam logic [2:0] SRC1_ERROR_EXT  = 3'd2;
    localparam logic [2:0] SRC1_ERROR_TOP  = 3'd3;
    localparam logic [2:0] SRC1_FWD        = 3'd4;

    typedef struct packed {
        logic [2:0] src0sel;
        logic [2:0] src1sel;
        logic       multiply;
        logic       sub;
        logic       mult2;
        logic       mult4;
        logic       saturate;
    } ctrl_t;

    // ALU control word driven while the sequencer sits in a given state
    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ERR: begin
                c.src1sel  = SRC1_FWD;
                c.src0sel  = SRC0_A2D_RES;
                c.sub      = 1'b1;
                c.saturate = 1'b1;
            end
            INTG: begin
                c.src1sel  = SRC1_ERROR_TOP;
                c.src0sel  = SRC0_INTGRL_EXT;
                c.saturate = 1'b1;
            end
            ICOMP: begin
                c.src1sel  = SRC1_ITERM;
                c.src0sel  = SRC0_INTGRL_EXT;
                c.multiply = 1'b1;
            end
            PCOMP: begin
                c.src1sel  = SRC1_ERROR_EXT;
                c.src0sel  = SRC0_PTERM;
                c.multiply = 1'b1;
            end
            ACC1: begin
                c.src1sel  = SRC1_FWD;
                c.src0sel  = SRC0_PCOMP;
            end
            ACC2: begin
                c.src1sel  = SRC1_ACCUM;
                c.src0sel  = SRC0_ICOMP_EXT;
                c.mult2    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pid_math_seq.sv
// Sequencer for the shared PID ALU: steps the ALU through the balance-loop
// equation once per go, capturing each ALU result into its register.
module pid_math_seq
    import pid_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        clr_intgrl,
    input  logic        freeze_intgrl,
    input  logic [15:0] dst,
    output logic [2:0]  src0sel,
    output logic [2:0]  src1sel,
    output logic        multiply,
    output logic        sub,
    output logic        mult2,
    output logic        mult4,
    output logic        saturate,
    output logic [11:0] error,
    output logic [11:0] intgrl,
    output logic [11:0] icomp,
    output logic [15:0] pcomp,
    output logic [15:0] accum,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] LAST_CNT = 3'(MULT_CYCLES - 1);

    state_t     state;
    state_t     nxt;
    logic [2:0] cnt;
    logic       last;
    ctrl_t      ctrl;

    assign src0sel  = ctrl.src0sel;
    assign src1sel  = ctrl.src1sel;
    assign multiply = ctrl.multiply;
    assign sub      = ctrl.sub;
    assign mult2    = ctrl.mult2;
    assign mult4    = ctrl.mult4;
    assign saturate = ctrl.saturate;

    // Next-state decode; multiply steps leave once the cycle counter reaches the last cycle
    always_comb begin
        nxt  = state;
        last = (cnt == LAST_CNT);
        case (state)
            IDLE:    if (go) nxt = ERR;
            ERR:     nxt = INTG;
            INTG:    nxt = ICOMP;
            ICOMP:   if (last) nxt = PCOMP;
            PCOMP:   if (last) nxt = ACC1;
            ACC1:    nxt = ACC2;
            ACC2:    nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // FSM, registered ALU controls/status, and result captures on the last cycle of each step.
    // Controls are decoded from the next state so they are valid for the whole step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ctrl   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= '0;
            intgrl <= '0;
            icomp  <= '0;
            pcomp  <= '0;
            accum  <= '0;
        end else begin
            state <= nxt;
            ctrl  <= ctrl_decode(nxt);
            busy  <= (nxt != IDLE);
            done  <= (nxt == DONE);
            cnt   <= (nxt != state || state == IDLE) ? '0 : cnt + 3'd1;

            case (state)
                ERR:   error <= dst[11:0];
                INTG:  if (!freeze_intgrl) intgrl <= dst[11:0];
                ICOMP: if (last) icomp <= dst[11:0];
                PCOMP: if (last) pcomp <= dst;
                ACC1:  accum <= dst;
                ACC2:  accum <= dst;
                default: ;
            endcase

            // Placed after the capture so a clear wins over an INTG update
            if (clr_intgrl) intgrl <= '0;
        end
    end

endmodule
